// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, register-file write selection,
// NZP condition codes and a retired-instruction counter.
module writeback_stage #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_mem_wb,
  input  logic                 mem_stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic [3:0]           opcode,
  input  logic [2:0]           dest_reg,
  input  logic [15:0]          alu_out,
  input  logic [15:0]          pc_plus2,
  input  logic [15:0]          dmem_rdata_out,
  output logic                 regfile_load,
  output logic [2:0]           regfile_dest,
  output logic [15:0]          regfile_data,
  output logic [2:0]           cc_nzp,
  output logic                 wb_valid,
  output logic [CNT_WIDTH-1:0] retire_count
);

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  logic                 valid_q,  valid_d;
  opcode_e              opcode_q, opcode_d;
  logic [2:0]           dest_q,   dest_d;
  logic [15:0]          alu_q,    alu_d;
  logic [15:0]          pc_q,     pc_d;
  logic [15:0]          rdata_q,  rdata_d;
  logic [2:0]           cc_q,     cc_d;
  logic [CNT_WIDTH-1:0] retire_q, retire_d;

  logic        wr_en;
  logic        sets_cc;
  logic [2:0]  wr_dest;
  logic [15:0] wr_data;
  logic [7:0]  ld_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      opcode_q <= OP_BR;
      dest_q   <= '0;
      alu_q    <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
      cc_q     <= 3'b010;
      retire_q <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      alu_q    <= alu_d;
      pc_q     <= pc_d;
      rdata_q  <= rdata_d;
      cc_q     <= cc_d;
      retire_q <= retire_d;
    end
  end

  // Any cycle without a fresh capture becomes a bubble, so an instruction
  // occupies WB for exactly one cycle even when upstream is frozen.
  always_comb begin
    valid_d  = 1'b0;
    opcode_d = opcode_q;
    dest_d   = dest_q;
    alu_d    = alu_q;
    pc_d     = pc_q;
    rdata_d  = rdata_q;
    if (flush || mem_stall) begin
      valid_d = 1'b0;
    end else if (load_mem_wb) begin
      valid_d  = mem_valid;
      opcode_d = opcode_e'(opcode);
      dest_d   = dest_reg;
      alu_d    = alu_out;
      pc_d     = pc_plus2;
      rdata_d  = dmem_rdata_out;
    end
  end

  assign ld_byte = alu_q[0] ? rdata_q[15:8] : rdata_q[7:0];

  always_comb begin
    wr_en   = 1'b0;
    sets_cc = 1'b0;
    wr_dest = dest_q;
    wr_data = alu_q;
    case (opcode_q)
      OP_ADD, OP_AND, OP_NOT, OP_SHF: begin
        wr_en   = 1'b1;
        sets_cc = 1'b1;
      end
      OP_LEA: begin
        wr_en = 1'b1;
      end
      OP_LDR, OP_LDI: begin
        wr_en   = 1'b1;
        sets_cc = 1'b1;
        wr_data = rdata_q;
      end
      OP_LDB: begin
        wr_en   = 1'b1;
        sets_cc = 1'b1;
        wr_data = {8'h00, ld_byte};
      end
      OP_JSR, OP_TRAP: begin
        wr_en   = 1'b1;
        wr_dest = 3'd7;
        wr_data = pc_q;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    cc_d     = cc_q;
    retire_d = retire_q;
    if (valid_q) begin
      retire_d = retire_q + CNT_WIDTH'(1);
      if (sets_cc) begin
        cc_d = {wr_data[15], (wr_data == '0), (!wr_data[15] && (wr_data != '0))};
      end
    end
  end

  assign regfile_load = valid_q && wr_en;
  assign regfile_dest = wr_dest;
  assign regfile_data = wr_data;
  assign cc_nzp       = cc_q;
  assign wb_valid     = valid_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes model predictions,
// a negedge monitor pops and compares whenever WB holds an instruction.
module tb_writeback_stage;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_mem_wb, mem_stall, flush, mem_valid;
  logic [3:0]    opcode;
  logic [2:0]    dest_reg;
  logic [15:0]   alu_out, pc_plus2, dmem_rdata_out;
  logic          regfile_load;
  logic [2:0]    regfile_dest;
  logic [15:0]   regfile_data;
  logic [2:0]    cc_nzp;
  logic          wb_valid;
  logic [CW-1:0] retire_count;

  always #5 clk = ~clk;

  writeback_stage #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .load_mem_wb(load_mem_wb), .mem_stall(mem_stall),
    .flush(flush), .mem_valid(mem_valid), .opcode(opcode), .dest_reg(dest_reg),
    .alu_out(alu_out), .pc_plus2(pc_plus2), .dmem_rdata_out(dmem_rdata_out),
    .regfile_load(regfile_load), .regfile_dest(regfile_dest), .regfile_data(regfile_data),
    .cc_nzp(cc_nzp), .wb_valid(wb_valid), .retire_count(retire_count)
  );

  typedef struct {
    logic          wr;
    logic [2:0]    dest;
    logic [15:0]   data;
    logic [2:0]    cc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            failures = 0;
  logic [2:0]    m_cc;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the instruction writes and how architectural state moves on.
  task automatic model_push(input logic [3:0] op, input logic [2:0] d,
                            input logic [15:0] a, input logic [15:0] p, input logic [15:0] r);
    exp_t e;
    bit   upd_cc;
    int   v;
    e.cc   = m_cc;
    e.cnt  = m_cnt;
    e.wr   = 1'b0;
    e.dest = d;
    e.data = a;
    upd_cc = 1'b0;
    case (int'(op))
      1, 5, 9, 13: begin e.wr = 1'b1; upd_cc = 1'b1; end
      14:          begin e.wr = 1'b1; end
      6, 10:       begin e.wr = 1'b1; upd_cc = 1'b1; e.data = r; end
      2: begin
        e.wr = 1'b1; upd_cc = 1'b1;
        e.data = (a % 2 == 1) ? 16'(r / 256) : 16'(r % 256);
      end
      4, 15:       begin e.wr = 1'b1; e.dest = 3'd7; e.data = p; end
      default: ;
    endcase
    if (upd_cc) begin
      v = int'($signed(e.data));
      m_cc = (v < 0) ? 3'b100 : (v == 0) ? 3'b010 : 3'b001;
    end
    m_cnt = CW'((int'(m_cnt) + 1) % (1 << CW));
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs (called at posedge+1), return at the next posedge+1.
  task automatic step(input bit ld, input bit st, input bit fl, input bit mv,
                      input logic [3:0] op, input logic [2:0] d,
                      input logic [15:0] a, input logic [15:0] p, input logic [15:0] r);
    load_mem_wb = ld; mem_stall = st; flush = fl; mem_valid = mv;
    opcode = op; dest_reg = d; alu_out = a; pc_plus2 = p; dmem_rdata_out = r;
    if (ld && !st && !fl && mv) model_push(op, d, a, p, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 16'h0, 16'h0, 16'h0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (wb_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb: got wb_valid 1 expected no instruction at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("wr_en", 32'(regfile_load), 32'(e.wr));
          if (e.wr) begin
            chk("wr_dest", 32'(regfile_dest), 32'(e.dest));
            chk("wr_data", 32'(regfile_data), 32'(e.data));
          end
          chk("cc_in_wb", 32'(cc_nzp), 32'(e.cc));
          chk("cnt_in_wb", 32'(retire_count), 32'(e.cnt));
        end
      end else begin
        chk("bubble_no_write", 32'(regfile_load), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    load_mem_wb = 1'b0; mem_stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    opcode = '0; dest_reg = '0; alu_out = '0; pc_plus2 = '0; dmem_rdata_out = '0;
    m_cc = 3'b010;
    m_cnt = '0;
    #12;
    chk("rst_load", 32'(regfile_load), 32'(0));
    chk("rst_valid", 32'(wb_valid), 32'(0));
    chk("rst_cc", 32'(cc_nzp), 32'(3'b010));
    chk("rst_cnt", 32'(retire_count), 32'(0));
    chk("rst_dest", 32'(regfile_dest), 32'(0));
    chk("rst_data", 32'(regfile_data), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ADD negative result
    step(1, 0, 0, 1, 4'b0001, 3'd3, 16'h8001, 16'h0, 16'h0);
    chk("add_load", 32'(regfile_load), 32'(1));
    chk("add_data", 32'(regfile_data), 32'h8001);
    idle();
    chk("add_cc", 32'(cc_nzp), 32'(3'b100));
    chk("add_cnt", 32'(retire_count), 32'(1));
    chk("add_one_cycle", 32'(regfile_load), 32'(0));

    // LDB high and low byte
    step(1, 0, 0, 1, 4'b0010, 3'd1, 16'h1001, 16'h0, 16'hA55A);
    chk("ldb_hi_data", 32'(regfile_data), 32'h00A5);
    idle();
    chk("ldb_hi_cc", 32'(cc_nzp), 32'(3'b001));
    step(1, 0, 0, 1, 4'b0010, 3'd1, 16'h1000, 16'h0, 16'hA55A);
    chk("ldb_lo_data", 32'(regfile_data), 32'h005A);

    // JSR links to R7 and keeps CC
    step(1, 0, 0, 1, 4'b0100, 3'd5, 16'h1234, 16'h0302, 16'h0);
    chk("jsr_dest", 32'(regfile_dest), 32'(7));
    chk("jsr_data", 32'(regfile_data), 32'h0302);
    idle();
    chk("jsr_cc", 32'(cc_nzp), 32'(3'b001));

    // STR retires without writing
    step(1, 0, 0, 1, 4'b0111, 3'd2, 16'h0040, 16'h0, 16'h0);
    chk("str_load", 32'(regfile_load), 32'(0));
    chk("str_valid", 32'(wb_valid), 32'(1));
    idle();
    chk("str_cnt", 32'(retire_count), 32'(5));

    // Stall blocks capture
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 4'b0001, 3'd4, 16'h0007, 16'h0, 16'h0);
      chk("stall_valid", 32'(wb_valid), 32'(0));
    end
    chk("stall_cnt", 32'(retire_count), 32'(5));
    step(1, 0, 0, 1, 4'b0110, 3'd6, 16'h0100, 16'h0, 16'h0000);
    chk("ldr0_load", 32'(regfile_load), 32'(1));
    chk("ldr0_data", 32'(regfile_data), 32'h0000);
    idle();
    chk("ldr0_cc", 32'(cc_nzp), 32'(3'b010));

    // Flush squashes incoming; flush+stall is a bubble
    step(1, 0, 1, 1, 4'b0001, 3'd3, 16'h0009, 16'h0, 16'h0);
    chk("flush_valid", 32'(wb_valid), 32'(0));
    step(1, 1, 1, 1, 4'b0001, 3'd3, 16'h0009, 16'h0, 16'h0);
    chk("flush_stall_valid", 32'(wb_valid), 32'(0));
    idle();
    chk("flush_cc", 32'(cc_nzp), 32'(3'b010));

    // Flush does not cancel the instruction already in WB
    step(1, 0, 0, 1, 4'b0101, 3'd2, 16'h0003, 16'h0, 16'h0);
    step(1, 0, 1, 1, 4'b0001, 3'd3, 16'hFFFF, 16'h0, 16'h0);
    chk("flush_wb_valid_after", 32'(wb_valid), 32'(0));
    chk("flush_wb_cc", 32'(cc_nzp), 32'(3'b001));

    // Reset while an instruction sits in WB
    step(1, 0, 0, 1, 4'b0001, 3'd2, 16'h0005, 16'h0, 16'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_load", 32'(regfile_load), 32'(0));
    chk("midrst_valid", 32'(wb_valid), 32'(0));
    chk("midrst_cc", 32'(cc_nzp), 32'(3'b010));
    chk("midrst_cnt", 32'(retire_count), 32'(0));
    void'(sbq.pop_back());
    m_cc = 3'b010;
    m_cnt = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Counter wraps after 2^CW retirements
    for (int i = 0; i < (1 << CW); i++)
      step(1, 0, 0, 1, 4'($urandom_range(0, 15)), 3'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom));
    idle();
    chk("cnt_wrap", 32'(retire_count), 32'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 80),
           4'($urandom_range(0, 15)), 3'($urandom),
           (($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom)), 16'($urandom),
           (($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom)));
    end

    repeat (3) idle();
    chk("sb_drained", 32'(sbq.size()), 32'(0));
    chk("final_cc", 32'(cc_nzp), 32'(m_cc));
    chk("final_cnt", 32'(retire_count), 32'(m_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Latches the memory stage's results through the MEM/WB pipeline register.
- Selects the register-file write data: ALU result, loaded word, zero-extended loaded byte, or return PC.
- Drives the register-file write port, the NZP condition-code register and a retired-instruction counter.
- Write-port outputs double as the WB-stage forwarding source for the decode and execute stages.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- load_mem_wb  input  1  advance enable for the MEM/WB register.
- mem_stall  input  1  memory stage is waiting on dmem.
- flush  input  1  squash the instruction entering WB.
- mem_valid  input  1  memory stage holds a real instruction (not a bubble).
- opcode  input  4  LC-3b opcode of the MEM-stage instruction.
- dest_reg  input  3  destination register field.
- alu_out  input  16  ALU result; also the data address.
- pc_plus2  input  16  incremented PC of the instruction.
- dmem_rdata_out  input  16  word selected from the dmem line.
- regfile_load  output  1  register-file write enable.
- regfile_dest  output  3  register-file write index.
- regfile_data  output  16  register-file write data.
- cc_nzp  output  3  condition codes {n,z,p}.
- wb_valid  output  1  a valid instruction occupies WB this cycle.
- retire_count  output  CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - valid_q=0, so wb_valid=0 and regfile_load=0.
  - All latched fields are 0, so regfile_dest=0 and regfile_data=0.
  - cc_nzp=3'b010 (Z set).
  - retire_count=0.
  - Reset asserted mid-operation discards any in-flight instruction; no write occurs.
- MEM/WB register update, evaluated at each rising edge in this priority order:
  1. flush=1: valid_q<=0. The data fields may load or hold; they are don't-care.
  2. mem_stall=1: valid_q<=0, i.e. a bubble. This prevents a duplicate writeback while upstream is frozen.
  3. load_mem_wb=1: capture opcode, dest_reg, alu_out, pc_plus2 and dmem_rdata_out; valid_q<=mem_valid.
  4. Otherwise: hold the data fields and set valid_q<=0. Each captured instruction is valid for exactly one cycle.
- Latency: an instruction captured at edge N drives the write port during cycle N+1. The register file and CC register sample it at edge N+1.
- Write decode, combinational from the latched fields:
  - ADD(0001), AND(0101), NOT(1001), SHF(1101), LEA(1110), LDR(0110), LDI(1010), LDB(0010):
    - dest = dest_q.
    - Data: alu_q for ADD, AND, NOT, SHF, LEA; rdata_q for LDR and LDI; the selected byte for LDB.
  - JSR(0100), TRAP(1111): dest = 3'd7, data = pc_plus2_q.
  - All other opcodes (BR, STB, STR, STI, JMP, RTI): no register write.
- LDB byte select:
  - alu_q[0]=0 → data = {8'h00, rdata_q[7:0]}.
  - alu_q[0]=1 → data = {8'h00, rdata_q[15:8]}.
  - The byte is always zero-extended.
- regfile_load = valid_q AND opcode writes a register. regfile_dest and regfile_data follow the decode regardless of valid_q.
- wb_valid = valid_q.
- Condition codes: at an edge where valid_q=1 and the opcode is one of ADD, AND, NOT, SHF, LDR, LDI or LDB:
  - cc_nzp <= {data[15], data==0, !data[15] && data!=0}.
  - LEA, JSR and TRAP leave cc_nzp unchanged.
  - Exactly one CC bit is set at all times after reset.
- retire_count increments by 1 at each edge where valid_q=1, for any opcode. It wraps modulo 2^CNT_WIDTH with no saturation.
- Simultaneous events:
  - flush and mem_stall both high: flush wins; the result is the same bubble.
  - flush asserted in the same cycle as a valid WB instruction does not cancel that instruction's write; only the incoming instruction is squashed.
- No state machine beyond valid_q. The block never stalls upstream.

Test Plan:
- Reset → regfile_load=0, wb_valid=0, cc_nzp=3'b010, retire_count=0. Assert reset_n=0 mid-stream with valid_q=1 → write suppressed immediately.
- ADD, dest=3, alu_out=16'h8001, mem_valid=1, load_mem_wb=1 → next cycle regfile_load=1, dest=3, data=16'h8001. After that edge cc_nzp=3'b100 and retire_count=1; the cycle after, regfile_load=0.
- LDB, alu_out=16'h1001, dmem_rdata_out=16'hA55A → data=16'h00A5, cc_nzp=3'b001. Repeat with alu_out=16'h1000 → data=16'h005A.
- JSR, pc_plus2=16'h0302, dest_reg=5 → dest=7, data=16'h0302, cc_nzp unchanged. STR → regfile_load=0 and retire_count still increments.
- mem_stall=1 for 3 cycles with load_mem_wb=1 → wb_valid=0 throughout, no writes, retire_count unchanged. Drop the stall and capture LDR with rdata 16'h0000 → one write of 0, cc_nzp=3'b010.
- flush=1 while capturing ADD → no write and no CC change. flush=1 and mem_stall=1 together → bubble. Preload retire_count at 2^CNT_WIDTH-1 with CNT_WIDTH=4, retire one instruction → retire_count=0.
